// File: rtl/ws2812_rx_if.sv
// ---------------------------------------------------------------------------
// ws2812_rx_if : output bundle of the WS2812 stream decoder.
//
// The decoder drives everything here (master modport); the consumer
// (loopback checker, diagnostics logic) samples it (slave modport).
//
// Signals:
//   pixel_valid    one-cycle pulse: pixel_data / px_num are valid
//   pixel_data     last decoded pixel, first received bit in the MSB, held
//   px_num         index of the presented pixel, 0 = first after a latch
//   frame_done     one-cycle pulse on a latch gap that followed received bits
//   frame_px_count pixels in the last completed frame, held
//   err            one-cycle pulse per protocol violation
//   len_mismatch   sticky frame-length flag, present only when
//                  WS2812_RX_LEN_CHECK_EN is defined
// ---------------------------------------------------------------------------
interface ws2812_rx_if #(
  parameter int PX_COUNT_WIDTH = 6,
  parameter int BITS_PER_PIXEL = 24
);
  logic                      pixel_valid;
  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic [PX_COUNT_WIDTH-1:0] px_num;
  logic                      frame_done;
  logic [PX_COUNT_WIDTH:0]   frame_px_count;
  logic                      err;
`ifdef WS2812_RX_LEN_CHECK_EN
  logic                      len_mismatch;

  modport master (
    output pixel_valid, pixel_data, px_num, frame_done, frame_px_count, err,
           len_mismatch
  );
  modport slave (
    input  pixel_valid, pixel_data, px_num, frame_done, frame_px_count, err,
           len_mismatch
  );
`else
  modport master (
    output pixel_valid, pixel_data, px_num, frame_done, frame_px_count, err
  );
  modport slave (
    input  pixel_valid, pixel_data, px_num, frame_done, frame_px_count, err
  );
`endif
endinterface

// File: rtl/ws2812_rx.sv
// ---------------------------------------------------------------------------
// ws2812_rx : WS2812 one-wire stream decoder.
//
// Decodes the pulse-width coded serial stream into BITS_PER_PIXEL-bit pixel
// words (MSB first), indexed from the last latch (low gap of T_RESET_CYCLES).
// Used to loop back / snoop a strip driver's data line.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   din    raw serial input (asynchronous, synchronised internally)
//   rx     ws2812_rx_if.master output bundle (pixel_valid, pixel_data,
//          px_num, frame_done, frame_px_count, err [, len_mismatch])
//
// Optional feature: define WS2812_RX_LEN_CHECK_EN to compare every completed
// frame against EXPECTED_PX; a mismatch pulses err together with frame_done
// and sets the sticky len_mismatch flag (cleared only by reset).
// ---------------------------------------------------------------------------
module ws2812_rx #(
  parameter int PX_COUNT_WIDTH    = 6,
  parameter int BITS_PER_PIXEL    = 24,
  parameter int T1_MIN_CYCLES     = 60,
  parameter int T_GLITCH_CYCLES   = 10,
  parameter int T_HIGH_MAX_CYCLES = 200,
  parameter int T_RESET_CYCLES    = 5000,
  parameter int EXPECTED_PX       = 52
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  ws2812_rx_if.master rx
);

  localparam int HI_W = $clog2(T_HIGH_MAX_CYCLES + 1);
  localparam int LO_W = $clog2(T_RESET_CYCLES + 1);
  localparam int BC_W = $clog2(BITS_PER_PIXEL);
  localparam int PX_W = PX_COUNT_WIDTH + 1;

  localparam logic [HI_W-1:0] HI_MAX    = HI_W'(T_HIGH_MAX_CYCLES);
  localparam logic [HI_W-1:0] HI_ONE    = HI_W'(T1_MIN_CYCLES);
  localparam logic [HI_W-1:0] HI_GLITCH = HI_W'(T_GLITCH_CYCLES);
  localparam logic [LO_W-1:0] LO_MAX    = LO_W'(T_RESET_CYCLES);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(BITS_PER_PIXEL - 1);
  // One past the last addressable index: the saturated pixel count.
  localparam logic [PX_W-1:0] PX_LIMIT  = {1'b1, {PX_COUNT_WIDTH{1'b0}}};

`ifdef WS2812_RX_LEN_CHECK_EN
  localparam logic [PX_W-1:0] PX_EXPECT = PX_W'(EXPECTED_PX);
`else
  localparam int unused_expected_px = EXPECTED_PX;
`endif

  typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

  function automatic logic [HI_W-1:0] hi_sat_inc(input logic [HI_W-1:0] c);
    return (c == HI_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [LO_W-1:0] lo_sat_inc(input logic [LO_W-1:0] c);
    return (c == LO_MAX) ? c : c + 1'b1;
  endfunction

  logic            din_p0, din_s, din_d;
  logic            rise, fall;
  logic [HI_W-1:0] hi_cnt;
  logic [LO_W-1:0] lo_cnt;

  state_t                    state;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [BITS_PER_PIXEL-1:0] shift_nxt;
  logic                      bit_val;
  logic [BC_W-1:0]           bit_cnt;
  logic [PX_W-1:0]           px_idx;
  logic                      px_ovf;
  logic                      got_bit;

  logic                      pixel_valid_q;
  logic [BITS_PER_PIXEL-1:0] pixel_data_q;
  logic [PX_COUNT_WIDTH-1:0] px_num_q;
  logic                      frame_done_q;
  logic [PX_W-1:0]           frame_px_count_q;
  logic                      err_q;
`ifdef WS2812_RX_LEN_CHECK_EN
  logic                      len_mismatch_q;
`endif

  // ---- stage: input synchroniser and edge detect ----
  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // The edge cycle itself is counted (counters restart at 1), so at a fall
  // hi_cnt equals the number of cycles din_s was high, and likewise lo_cnt.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_p0 <= 1'b0;
      din_s  <= 1'b0;
      din_d  <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      din_p0 <= din;
      din_s  <= din_p0;
      din_d  <= din_s;
      if (rise)
        hi_cnt <= HI_W'(1);
      else if (din_s)
        hi_cnt <= hi_sat_inc(hi_cnt);
      if (fall)
        lo_cnt <= LO_W'(1);
      else if (!din_s)
        lo_cnt <= lo_sat_inc(lo_cnt);
    end
  end

  // ---- stage: bit decode, pixel assembly and frame control ----
  assign bit_val   = (hi_cnt >= HI_ONE);
  assign shift_nxt = {shreg[BITS_PER_PIXEL-2:0], bit_val};

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= WAIT_GAP;
      shreg            <= '0;
      bit_cnt          <= '0;
      px_idx           <= '0;
      px_ovf           <= 1'b0;
      got_bit          <= 1'b0;
      pixel_valid_q    <= 1'b0;
      pixel_data_q     <= '0;
      px_num_q         <= '0;
      frame_done_q     <= 1'b0;
      frame_px_count_q <= '0;
      err_q            <= 1'b0;
`ifdef WS2812_RX_LEN_CHECK_EN
      len_mismatch_q   <= 1'b0;
`endif
    end else begin
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      case (state)
        // Never trust a stream joined mid-frame: wait for a full latch gap.
        WAIT_GAP: begin
          if (!din_s && lo_cnt == LO_MAX)
            state <= IDLE;
        end
        IDLE: begin
          if (rise)
            state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
            if (hi_cnt < HI_GLITCH) begin
              err_q <= 1'b1;
            end else begin
              got_bit <= 1'b1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                shreg   <= '0;
                if (px_idx == PX_LIMIT) begin
                  // Index space exhausted: flag once, drop until the latch.
                  if (!px_ovf)
                    err_q <= 1'b1;
                  px_ovf <= 1'b1;
                end else begin
                  pixel_valid_q <= 1'b1;
                  pixel_data_q  <= shift_nxt;
                  px_num_q      <= px_idx[PX_COUNT_WIDTH-1:0];
                  px_idx        <= px_idx + 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shift_nxt;
              end
            end
          end else if (din_s && hi_cnt == HI_MAX) begin
            // Line stuck high: abandon the frame and resynchronise on a gap.
            err_q    <= 1'b1;
            state    <= WAIT_GAP;
            shreg    <= '0;
            bit_cnt  <= '0;
            px_idx   <= '0;
            px_num_q <= '0;
            px_ovf   <= 1'b0;
            got_bit  <= 1'b0;
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (lo_cnt == LO_MAX) begin
            state <= IDLE;
            if (bit_cnt != '0)
              err_q <= 1'b1;
            if (got_bit) begin
              frame_done_q     <= 1'b1;
              frame_px_count_q <= px_idx;
`ifdef WS2812_RX_LEN_CHECK_EN
              if (px_idx != PX_EXPECT) begin
                err_q          <= 1'b1;
                len_mismatch_q <= 1'b1;
              end
`endif
            end
            shreg   <= '0;
            bit_cnt <= '0;
            px_idx  <= '0;
            px_ovf  <= 1'b0;
            got_bit <= 1'b0;
          end
        end
        default: state <= WAIT_GAP;
      endcase
    end
  end

  // ---- stage: output bundle ----
  assign rx.pixel_valid    = pixel_valid_q;
  assign rx.pixel_data     = pixel_data_q;
  assign rx.px_num         = px_num_q;
  assign rx.frame_done     = frame_done_q;
  assign rx.frame_px_count = frame_px_count_q;
  assign rx.err            = err_q;
`ifdef WS2812_RX_LEN_CHECK_EN
  assign rx.len_mismatch   = len_mismatch_q;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// ---------------------------------------------------------------------------
// tb_ws2812_rx : self-checking bench for ws2812_rx (default build).
//
// A table of pixel records (data, bit timings, expected data/index, frame
// end and expected frame count) drives two frames; hand-written sequences
// cover glitch rejection and output latency, partial pixels, a stuck-high
// line, joining a stream without an initial gap and reset mid-pixel.
// ---------------------------------------------------------------------------
module tb_ws2812_rx;

  localparam int W   = 6;
  localparam int BPP = 24;
  localparam int GAP = 5010;
  localparam int F0H = 20;
  localparam int F0L = 15;
  localparam int F1H = 70;
  localparam int F1L = 15;

  logic clk = 1'b0;
  logic reset;
  logic din;

  always #5 clk = ~clk;

  ws2812_rx_if #(.PX_COUNT_WIDTH(W), .BITS_PER_PIXEL(BPP)) rx_if ();

  ws2812_rx dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rx    (rx_if)
  );

  typedef struct {
    logic [23:0] px;
    int          t0h;
    int          t0l;
    int          t1h;
    int          t1l;
    logic [23:0] exp_data;
    int          exp_num;
    bit          last;
    int          exp_count;
  } vec_t;

  vec_t vecs[5];

  // Output monitor, sampled on the falling edge.
  logic [23:0]  cap_data[$];
  int           cap_num[$];
  int           n_err   = 0;
  int           n_fd    = 0;
  int           n_coinc = 0;
  logic         last_fd_err = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.pixel_valid) begin
        cap_data.push_back(rx_if.pixel_data);
        cap_num.push_back(int'(rx_if.px_num));
      end
      if (rx_if.err)
        n_err++;
      if (rx_if.frame_done) begin
        n_fd++;
        last_fd_err = rx_if.err;
      end
      if (rx_if.err && rx_if.pixel_valid)
        n_coinc++;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int t0h, input int t0l,
                          input int t1h, input int t1l);
    if (b) begin
      hold(1'b1, t1h);
      hold(1'b0, t1l);
    end else begin
      hold(1'b1, t0h);
      hold(1'b0, t0l);
    end
  endtask

  task automatic send_px(input logic [23:0] px, input int t0h, input int t0l,
                         input int t1h, input int t1l);
    for (int i = 23; i >= 0; i--)
      send_bit(px[i], t0h, t0l, t1h, t1l);
  endtask

  // Bits hi_b down to lo_b of px with the fast timing set.
  task automatic send_bits(input logic [23:0] px, input int hi_b, input int lo_b);
    for (int i = hi_b; i >= lo_b; i--)
      send_bit(px[i], F0H, F0L, F1H, F1L);
  endtask

  task automatic check_pixel(input string name, input int q0,
                             input logic [23:0] exp_d, input int exp_n);
    check({name, "_count"}, cap_data.size() - q0, 1);
    if (cap_data.size() > q0) begin
      check({name, "_data"}, cap_data[q0], exp_d);
      check({name, "_num"}, cap_num[q0], exp_n);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, rx_if.pixel_valid, 0);
    check({name, "_data"}, rx_if.pixel_data, 0);
    check({name, "_num"}, rx_if.px_num, 0);
    check({name, "_fd"}, rx_if.frame_done, 0);
    check({name, "_fcount"}, rx_if.frame_px_count, 0);
    check({name, "_err"}, rx_if.err, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          q0, e0, f0, fr_e0, fr_f0;
    logic [23:0] v;

    vecs[0] = '{24'hFF0000, 40, 85, 80, 45, 24'hFF0000, 0, 1'b0, 0};
    vecs[1] = '{24'h5AA5C3, 40, 85, 80, 45, 24'h5AA5C3, 1, 1'b0, 0};
    vecs[2] = '{24'h000001, 40, 85, 80, 45, 24'h000001, 2, 1'b1, 3};
    vecs[3] = '{24'hC3C3C3, 59, 20, 60, 20, 24'hC3C3C3, 0, 1'b0, 0};
    vecs[4] = '{24'h0F0F0F, 10, 12, 150, 10, 24'h0F0F0F, 1, 1'b1, 2};

    // Reset state
    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    hold(1'b0, 6000);

    // Table-driven frames
    fr_e0 = n_err;
    fr_f0 = n_fd;
    for (int i = 0; i < 5; i++) begin
      q0 = cap_data.size();
      send_px(vecs[i].px, vecs[i].t0h, vecs[i].t0l, vecs[i].t1h, vecs[i].t1l);
      check_pixel($sformatf("vec%0d", i), q0, vecs[i].exp_data, vecs[i].exp_num);
      if (vecs[i].last) begin
        hold(1'b0, GAP);
        check($sformatf("vec%0d_frame_done", i), n_fd - fr_f0, 1);
        check($sformatf("vec%0d_frame_px_count", i), rx_if.frame_px_count,
              vecs[i].exp_count);
        check($sformatf("vec%0d_no_err", i), n_err - fr_e0, 0);
        fr_e0 = n_err;
        fr_f0 = n_fd;
      end
    end

    // Glitch inside a pixel, plus output latency of the last bit
    v  = 24'h3C5A96;
    q0 = cap_data.size();
    e0 = n_err;
    f0 = n_fd;
    send_bits(v, 23, 12);
    hold(1'b1, 5);
    hold(1'b0, 30);
    send_bits(v, 11, 1);
    hold(1'b1, v[0] ? F1H : F0H);
    din = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("latency_edge2", rx_if.pixel_valid, 0);
    @(posedge clk); #1;
    check("latency_edge3", rx_if.pixel_valid, 1);
    hold(1'b0, GAP);
    check("glitch_err", n_err - e0, 1);
    check_pixel("glitch_px", q0, 24'h3C5A96, 0);
    check("glitch_frame_done", n_fd - f0, 1);
    check("glitch_frame_px_count", rx_if.frame_px_count, 1);

    // Partial pixel: 12 bits then a gap
    q0 = cap_data.size();
    e0 = n_err;
    f0 = n_fd;
    send_bits(24'hABC000, 23, 12);
    hold(1'b0, GAP);
    check("partial_err", n_err - e0, 1);
    check("partial_frame_done", n_fd - f0, 1);
    check("partial_err_with_fd", last_fd_err, 1);
    check("partial_frame_px_count", rx_if.frame_px_count, 0);
    check("partial_no_pixel", cap_data.size() - q0, 0);

    // Stuck high mid-pixel
    q0 = cap_data.size();
    e0 = n_err;
    f0 = n_fd;
    send_bits(24'hF00000, 23, 19);
    hold(1'b1, 300);
    check("stuck_err", n_err - e0, 1);
    hold(1'b0, GAP);
    check("stuck_no_pixel", cap_data.size() - q0, 0);
    check("stuck_no_fd", n_fd - f0, 0);
    send_px(24'hA5A5A5, F0H, F0L, F1H, F1L);
    check_pixel("stuck_next", q0, 24'hA5A5A5, 0);
    hold(1'b0, GAP);
    check("stuck_next_fd", n_fd - f0, 1);
    check("stuck_next_fcount", rx_if.frame_px_count, 1);
    check("stuck_err_total", n_err - e0, 1);

    // No initial gap after reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q0 = cap_data.size();
    e0 = n_err;
    f0 = n_fd;
    send_px(24'hABCDEF, F0H, F0L, F1H, F1L);
    hold(1'b0, GAP);
    check("nogap_ignored", cap_data.size() - q0, 0);
    check("nogap_no_fd", n_fd - f0, 0);
    send_px(24'h123456, F0H, F0L, F1H, F1L);
    check_pixel("nogap_px", q0, 24'h123456, 0);
    check("nogap_no_err", n_err - e0, 0);

    // Reset after 10 bits of the next pixel
    send_bits(24'hFFC000, 23, 14);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    q0 = cap_data.size();
    e0 = n_err;
    f0 = n_fd;
    send_px(24'h777777, F0H, F0L, F1H, F1L);
    hold(1'b0, GAP);
    check("midreset_needs_gap", cap_data.size() - q0, 0);
    send_px(24'h0F1E2D, F0H, F0L, F1H, F1L);
    check_pixel("midreset_px", q0, 24'h0F1E2D, 0);
    hold(1'b0, GAP);
    check("midreset_fd", n_fd - f0, 1);
    check("midreset_fcount", rx_if.frame_px_count, 1);
    check("midreset_no_err", n_err - e0, 0);

    check("err_valid_never_coincide", n_coinc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
